mux13_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 3-source, 8-bit select datapath. Three requesters compete for one registered output slot:
- sources 0 and 1 carry full NBITS words;
- source 2 carries a 3-bit immediate that is formatted as {5'b11111, imm}.
The block grants one requester per cycle, drives the select code and the formatted data into an output register, and hands the word downstream with a valid/ready handshake. It sits between the datapath producers and the consumer of the mux output.

---
 rtl/mux13_pkg.sv | 16 +
 rtl/mux13_rr_arbiter_pick.sv | 36 +++
 rtl/mux13_rr_arbiter.sv | 68 ++++++
 tb/tb_mux13_rr_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mux13_pkg.sv
// Shared constants and types for the 3-source round-robin mux arbiter.
// The package holds the data width, the immediate pad, the select codes and the slot state encoding.
package mux13_pkg;

  localparam int NBITS = 8;
  localparam logic [4:0] IMM_PAD = 5'b11111;

  localparam logic [1:0] SEL_SRC0 = 2'b00;
  localparam logic [1:0] SEL_SRC1 = 2'b01;
  localparam logic [1:0] SEL_SRC2 = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t FULL  = 1'b1;

endpackage

// File: rtl/mux13_rr_arbiter_pick.sv
// Combinational circular priority picker for three requesters.
// The scan starts one position after the last winner and wraps around.
module rr_pick3
  import mux13_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  always_comb begin
    idx = SEL_SRC0;
    gnt = 3'b000;
    case (last)
      2'd0: begin
        if (req[1])      idx = SEL_SRC1;
        else if (req[2]) idx = SEL_SRC2;
        else             idx = SEL_SRC0;
      end
      2'd1: begin
        if (req[2])      idx = SEL_SRC2;
        else if (req[0]) idx = SEL_SRC0;
        else             idx = SEL_SRC1;
      end
      default: begin
        if (req[0])      idx = SEL_SRC0;
        else if (req[1]) idx = SEL_SRC1;
        else             idx = SEL_SRC2;
      end
    endcase
    // A lone requester falls through to the final branch, so it is never blocked by last.
    if (|req) gnt = 3'(3'b001 << idx);
  end

endmodule

// File: rtl/mux13_rr_arbiter.sv
// Round-robin arbiter feeding one registered output slot with a valid/ready handshake.
// Source 2 carries a short immediate that is padded with ones up to the full word width.
module mux13_rr_arbiter #(
  parameter int         NBITS    = 8,
  parameter logic [1:0] RST_LAST = 2'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       req,
  input  logic [NBITS-1:0] di0,
  input  logic [NBITS-1:0] di1,
  input  logic [NBITS-6:0] di2,
  output logic [2:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic [1:0]       out_sel
);
  import mux13_pkg::*;

  state_t           state;
  logic [1:0]       last;
  logic [2:0]       pick_gnt;
  logic [1:0]       pick_idx;
  logic             free;
  logic             grant;
  logic [NBITS-1:0] next_data;

  rr_pick3 u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign out_valid = (state == FULL);
  assign free      = (state == EMPTY) || (out_valid && out_ready);
  // Reset gates the grant so that no pulse escapes while the slot is being cleared.
  assign grant     = !rst && en && free && (|req);
  assign gnt       = grant ? pick_gnt : 3'b000;

  always_comb begin
    next_data = di0;
    case (pick_idx)
      SEL_SRC1: next_data = di1;
      SEL_SRC2: next_data = {IMM_PAD, di2};
      default:  next_data = di0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= SEL_SRC0;
      last     <= RST_LAST;
    end else if (grant) begin
      state    <= FULL;
      out_data <= next_data;
      out_sel  <= pick_idx;
      last     <= pick_idx;
    end else if (out_valid && out_ready) begin
      state    <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux13_rr_arbiter.sv
// Directed table-driven bench for the round-robin mux arbiter.
// gnt is checked just before each rising edge; registered outputs are checked on the following falling edge.
module tb_mux13_rr_arbiter;

  typedef struct {
    logic       en;
    logic [2:0] req;
    logic [7:0] di0;
    logic [7:0] di1;
    logic [2:0] di2;
    logic       ready;
    logic [2:0] exp_gnt;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] req;
  logic [7:0] di0;
  logic [7:0] di1;
  logic [2:0] di2;
  logic [2:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  mux13_rr_arbiter #(.NBITS(8), .RST_LAST(2'd2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .di0       (di0),
    .di1       (di1),
    .di2       (di2),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en        = v.en;
    req       = v.req;
    di0       = v.di0;
    di1       = v.di1;
    di2       = v.di2;
    out_ready = v.ready;
  endtask

  initial begin
    //                en  req     di0    di1    di2     rdy   gnt     vld   data   sel
    vecs.push_back('{1'b1, 3'b001, 8'h01, 8'h00, 3'd0, 1'b1, 3'b001, 1'b1, 8'h01, 2'd0});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 8'h00, 3'd2, 1'b1, 3'b100, 1'b1, 8'hFA, 2'd2});
    vecs.push_back('{1'b1, 3'b111, 8'h10, 8'h11, 3'd3, 1'b1, 3'b001, 1'b1, 8'h10, 2'd0});
    vecs.push_back('{1'b1, 3'b111, 8'h20, 8'h21, 3'd5, 1'b1, 3'b010, 1'b1, 8'h21, 2'd1});
    vecs.push_back('{1'b1, 3'b111, 8'h20, 8'h21, 3'd7, 1'b1, 3'b100, 1'b1, 8'hFF, 2'd2});
    vecs.push_back('{1'b1, 3'b111, 8'h30, 8'h31, 3'd7, 1'b1, 3'b001, 1'b1, 8'h30, 2'd0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1, 3'b011, 8'h40, 8'h41, 3'd0, 1'b0, 3'b000, 1'b1, 8'h30, 2'd0});
    vecs.push_back('{1'b1, 3'b011, 8'h40, 8'h41, 3'd0, 1'b1, 3'b010, 1'b1, 8'h41, 2'd1});
    vecs.push_back('{1'b0, 3'b011, 8'h40, 8'h41, 3'd0, 1'b1, 3'b000, 1'b0, 8'h41, 2'd1});
    vecs.push_back('{1'b0, 3'b011, 8'h40, 8'h41, 3'd0, 1'b1, 3'b000, 1'b0, 8'h41, 2'd1});
    vecs.push_back('{1'b1, 3'b011, 8'h50, 8'h51, 3'd0, 1'b1, 3'b001, 1'b1, 8'h50, 2'd0});
    vecs.push_back('{1'b1, 3'b000, 8'h00, 8'h00, 3'd0, 1'b0, 3'b000, 1'b1, 8'h50, 2'd0});
    vecs.push_back('{1'b1, 3'b000, 8'h00, 8'h00, 3'd0, 1'b1, 3'b000, 1'b0, 8'h50, 2'd0});
    vecs.push_back('{1'b1, 3'b010, 8'h00, 8'h60, 3'd0, 1'b1, 3'b010, 1'b1, 8'h60, 2'd1});
    vecs.push_back('{1'b1, 3'b010, 8'h00, 8'h61, 3'd0, 1'b1, 3'b010, 1'b1, 8'h61, 2'd1});
    vecs.push_back('{1'b1, 3'b000, 8'h00, 8'h00, 3'd0, 1'b1, 3'b000, 1'b0, 8'h61, 2'd1});
    vecs.push_back('{1'b1, 3'b100, 8'h00, 8'h00, 3'd0, 1'b0, 3'b100, 1'b1, 8'hF8, 2'd2});

    rst = 1'b1; en = 1'b0; req = 3'b000; di0 = '0; di1 = '0; di2 = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data",  32'(out_data),  32'h00);
    checkOutput("reset_sel",   32'(out_sel),   32'd0);
    checkOutput("reset_gnt",   32'(gnt),       32'b000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d_sel", i),   32'(out_sel),   32'(vecs[i].exp_sel));
    end

    // Asynchronous reset between edges while the slot is full and all sources request.
    en = 1'b1; req = 3'b111; di0 = 8'hA5; di1 = 8'h5A; di2 = 3'd1; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_gnt",   32'(gnt),       32'b000);
    checkOutput("arst_data",  32'(out_data),  32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_gnt", 32'(gnt), 32'b001);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_data",  32'(out_data),  32'hA5);
    checkOutput("post_rst_sel",   32'(out_sel),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
